sobel_scan_sequencer: RTL and testbench

Raster-scan controller for the Sobel gradient core. It accepts a frame of pixels from an upstream valid/ready source and drives the shift enable of the 3x3 window/line-buffer. It tracks the window-centre position and asserts `on_edge` for border centres. It also generates an output-valid strobe aligned to the core's registered result, plus frame start/done status.

---
 rtl/sobel_seq_pkg.sv | 18 +
 rtl/raster_counter.sv | 59 +++++
 rtl/sobel_scan_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_sobel_scan_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_seq_pkg.sv
// sobel_seq_pkg: shared types and constants for the Sobel raster-scan sequencer.
//   seq_state_t      - sequencer FSM states
//   MIN_DIM          - smallest legal frame width/height
//   DEFAULT_PIPE_LAT - default core latency from win_shift beat to pixel_out
package sobel_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN,
    FLUSH
  } seq_state_t;

  localparam int unsigned MIN_DIM          = 3;
  localparam int unsigned DEFAULT_PIPE_LAT = 2;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/row position counter with raster wrap.
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   clear              - synchronous return to (0,0); wins over en
//   en                 - advance one position
//   last_col_idx       - W-1; col wraps to 0 here and row advances
//   last_row_idx       - H-1; row wraps to 0 when the last column wraps here
//   col, row           - current position
//   last_col, last_row - position sits on the last column / last row
module raster_counter #(
  parameter int unsigned COL_BITS = 11,
  parameter int unsigned ROW_BITS = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                en,
  input  logic [COL_BITS-1:0] last_col_idx,
  input  logic [ROW_BITS-1:0] last_row_idx,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                last_col,
  output logic                last_row
);

  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;

  assign col      = col_q;
  assign row      = row_q;
  assign last_col = (col_q == last_col_idx);
  assign last_row = (row_q == last_row_idx);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sobel_scan_sequencer.sv
// sobel_scan_sequencer: raster-scan controller for the Sobel gradient core.
// Accepts one frame from a valid/ready source, drives the window shift enable,
// tracks the window centre and delays valid/edge flags to match the core.
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   start                 - begin a frame (sampled in IDLE only)
//   cfg_width, cfg_height - frame size, latched on an accepted start
//   in_valid / in_ready   - upstream pixel handshake
//   win_shift             - shift window/line buffers this cycle
//   on_edge               - current output centre lies on the frame border
//   out_valid             - core pixel_out valid this cycle
//   busy                  - frame in progress
//   done                  - one-cycle pulse at frame end
//   cfg_err               - one-cycle pulse on a rejected start
//   frame_count           - completed-frame counter (SOBEL_SEQ_FRAME_COUNT_EN only)
module sobel_scan_sequencer
  import sobel_seq_pkg::*;
#(
  parameter int unsigned WIDTH_BITS  = 11,
  parameter int unsigned HEIGHT_BITS = 11,
  parameter int unsigned PIPE_LAT    = DEFAULT_PIPE_LAT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH_BITS-1:0]  cfg_width,
  input  logic [HEIGHT_BITS-1:0] cfg_height,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   win_shift,
  output logic                   on_edge,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
`ifdef SOBEL_SEQ_FRAME_COUNT_EN
  ,
  output logic [15:0]            frame_count
`endif
);

  localparam int unsigned FLUSH_BITS = $clog2(PIPE_LAT + 1);

  seq_state_t             state_q, state_d;
  logic [WIDTH_BITS-1:0]  width_q, width_d;
  logic [HEIGHT_BITS-1:0] height_q, height_d;
  logic [WIDTH_BITS-1:0]  drain_q, drain_d;
  logic [FLUSH_BITS-1:0]  flush_q, flush_d;
  logic [PIPE_LAT-1:0]    vld_pipe_q, vld_pipe_d;
  logic [PIPE_LAT-1:0]    edge_pipe_q, edge_pipe_d;

  logic                   accept;
  logic                   issue;
  logic                   cnt_clear;
  logic                   cfg_ok;
  logic                   centre_edge;
  logic [WIDTH_BITS-1:0]  last_col_idx;
  logic [HEIGHT_BITS-1:0] last_row_idx;
  logic [WIDTH_BITS-1:0]  in_col, c_col;
  logic [HEIGHT_BITS-1:0] in_row, c_row;
  logic                   in_last_col, in_last_row;
  logic                   c_last_col, c_last_row;

  assign last_col_idx = width_q - WIDTH_BITS'(1);
  assign last_row_idx = height_q - HEIGHT_BITS'(1);
  assign cfg_ok       = (cfg_width >= WIDTH_BITS'(MIN_DIM)) &&
                        (cfg_height >= HEIGHT_BITS'(MIN_DIM));

  raster_counter #(
    .COL_BITS (WIDTH_BITS),
    .ROW_BITS (HEIGHT_BITS)
  ) u_in_cnt (
    .clock        (clock),
    .reset        (reset),
    .clear        (cnt_clear),
    .en           (accept),
    .last_col_idx (last_col_idx),
    .last_row_idx (last_row_idx),
    .col          (in_col),
    .row          (in_row),
    .last_col     (in_last_col),
    .last_row     (in_last_row)
  );

  raster_counter #(
    .COL_BITS (WIDTH_BITS),
    .ROW_BITS (HEIGHT_BITS)
  ) u_centre_cnt (
    .clock        (clock),
    .reset        (reset),
    .clear        (cnt_clear),
    .en           (issue),
    .last_col_idx (last_col_idx),
    .last_row_idx (last_row_idx),
    .col          (c_col),
    .row          (c_row),
    .last_col     (c_last_col),
    .last_row     (c_last_row)
  );

  assign centre_edge = (c_row == '0) || c_last_row || (c_col == '0) || c_last_col;

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    drain_d   = drain_q;
    flush_d   = flush_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    win_shift = 1'b0;
    done      = 1'b0;
    cfg_err   = 1'b0;
    cnt_clear = 1'b0;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            width_d   = cfg_width;
            height_d  = cfg_height;
            cnt_clear = 1'b1;
            state_d   = FILL;
          end else begin
            cfg_err = 1'b1;
          end
        end
      end

      FILL: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        win_shift = accept;
        // The input counter doubles as the fill counter: accept index W
        // (the W+1th) is the one taken at position (row 1, col 0).
        if (accept && (in_row == HEIGHT_BITS'(1)) && (in_col == '0)) begin
          state_d = RUN;
        end
      end

      RUN: begin
        in_ready  = 1'b1;
        accept    = in_valid;
        win_shift = accept;
        issue     = accept;
        if (accept && in_last_col && in_last_row) begin
          drain_d = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        win_shift = 1'b1;
        issue     = 1'b1;
        if (drain_q == width_q) begin
          flush_d = '0;
          state_d = FLUSH;
        end else begin
          drain_d = drain_q + WIDTH_BITS'(1);
        end
      end

      FLUSH: begin
        if (flush_q == FLUSH_BITS'(PIPE_LAT)) begin
          done    = 1'b1;
          busy    = 1'b0;
          state_d = IDLE;
        end else begin
          flush_d = flush_q + FLUSH_BITS'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    edge_pipe_d    = edge_pipe_q;
    vld_pipe_d[0]  = issue;
    edge_pipe_d[0] = issue && centre_edge;
    for (int unsigned i = 1; i < PIPE_LAT; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      edge_pipe_d[i] = edge_pipe_q[i-1];
    end
  end

  assign out_valid = vld_pipe_q[PIPE_LAT-1];
  assign on_edge   = edge_pipe_q[PIPE_LAT-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      drain_q     <= '0;
      flush_q     <= '0;
      vld_pipe_q  <= '0;
      edge_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      drain_q     <= drain_d;
      flush_q     <= flush_d;
      vld_pipe_q  <= vld_pipe_d;
      edge_pipe_q <= edge_pipe_d;
    end
  end

`ifdef SOBEL_SEQ_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (done) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_sobel_scan_sequencer.sv
// tb_sobel_scan_sequencer: directed self-checking bench for sobel_scan_sequencer.
// Define SOBEL_SEQ_FRAME_COUNT_EN to also exercise frame_count.
module tb_sobel_scan_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] cfg_width;
  logic [10:0] cfg_height;
  logic        in_valid;
  logic        in_ready;
  logic        win_shift;
  logic        on_edge;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef SOBEL_SEQ_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  sobel_scan_sequencer #(
    .WIDTH_BITS  (11),
    .HEIGHT_BITS (11),
    .PIPE_LAT    (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .win_shift  (win_shift),
    .on_edge    (on_edge),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
`ifdef SOBEL_SEQ_FRAME_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent frame.
  int          r_acc;
  int          r_drains;
  int          r_valids;
  int          r_done_gap;
  logic [63:0] r_ebits;
  bit          r_timeout;
  bit          r_busy_at_done;
  bit          r_start_busy;
  bit          r_first_busy;
  bit          r_first_ready;
  bit          r_edge_wo_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a frame and watches it until done (bounded). Drives from posedge+1,
  // samples at negedge. pulse_cyc >= 0 re-asserts start mid-frame.
  task automatic run_frame(input logic [10:0] w, input logic [10:0] h,
                           input bit toggle, input int pulse_cyc);
    int cyc;
    int last_v;
    int done_c;
    r_acc = 0; r_drains = 0; r_valids = 0; r_ebits = '0;
    r_busy_at_done = 1'b1; r_edge_wo_valid = 1'b0;
    cfg_width = w; cfg_height = h; start = 1'b1; in_valid = 1'b0;
    @(negedge clock);
    r_start_busy = busy;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0; last_v = -100; done_c = -1;
    while (done_c < 0 && cyc < 400) begin
      in_valid  = toggle ? (cyc % 2 == 0) : 1'b1;
      start     = (cyc == pulse_cyc);
      cfg_width = start ? 11'd7 : w;
      @(negedge clock);
      if (cyc == 0) begin
        r_first_busy  = busy;
        r_first_ready = in_ready;
      end
      if (in_valid && in_ready) r_acc++;
      if (win_shift && busy && !in_ready) r_drains++;
      if (on_edge && !out_valid) r_edge_wo_valid = 1'b1;
      if (out_valid) begin
        if (r_valids < 64) r_ebits[r_valids] = on_edge;
        r_valids++;
        last_v = cyc;
      end
      if (done) begin
        done_c = cyc;
        r_busy_at_done = busy;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; cfg_width = w;
    r_timeout  = (done_c < 0);
    r_done_gap = done_c - last_v;
  endtask

  initial begin
    int n;
    int guard;
    bit stray;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    cfg_width = '0; cfg_height = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {in_ready, win_shift, on_edge, out_valid, busy, done, cfg_err}, 7'b0);
`ifdef SOBEL_SEQ_FRAME_COUNT_EN
    chk("reset_frame_count", frame_count, 16'd0);
`endif
    reset = 1'b0;
    @(posedge clock); #1;

    // 4x3 frame, in_valid held high.
    run_frame(11'd4, 11'd3, 1'b0, -1);
    chk("f43_timeout", r_timeout, 1'b0);
    chk("f43_start_busy", r_start_busy, 1'b0);
    chk("f43_first_busy_ready", {r_first_busy, r_first_ready}, 2'b11);
    chk("f43_accepts", r_acc, 12);
    chk("f43_drain_shifts", r_drains, 5);
    chk("f43_valids", r_valids, 12);
    chk("f43_edge_bits", r_ebits, 64'hF9F);
    chk("f43_done_gap", r_done_gap, 1);
    chk("f43_busy_at_done", r_busy_at_done, 1'b0);
    chk("f43_edge_without_valid", r_edge_wo_valid, 1'b0);

    // Rejected starts: width 2, then height 2.
    cfg_width = 11'd2; cfg_height = 11'd3; start = 1'b1;
    @(negedge clock);
    chk("w2_err_cycle", {cfg_err, busy, in_ready}, 3'b100);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("w2_after", {cfg_err, busy, in_ready}, 3'b000);
    @(posedge clock); #1;
    cfg_width = 11'd3; cfg_height = 11'd2; start = 1'b1;
    @(negedge clock);
    chk("h2_err_cycle", {cfg_err, busy, in_ready}, 3'b100);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk("h2_after", {cfg_err, busy, in_ready}, 3'b000);
    @(posedge clock); #1;

    // Minimum legal frame 3x3: only the centre (1,1) is interior.
    run_frame(11'd3, 11'd3, 1'b0, -1);
    chk("f33_timeout", r_timeout, 1'b0);
    chk("f33_valids", r_valids, 9);
    chk("f33_edge_bits", r_ebits, 64'h1EF);
    chk("f33_drain_shifts", r_drains, 4);

    // 5x4 frame with in_valid toggling.
    run_frame(11'd5, 11'd4, 1'b1, -1);
    chk("f54_timeout", r_timeout, 1'b0);
    chk("f54_accepts", r_acc, 20);
    chk("f54_drain_shifts", r_drains, 6);
    chk("f54_valids", r_valids, 20);
    chk("f54_edge_bits", r_ebits, 64'hFC63F);
    chk("f54_done_gap", r_done_gap, 1);

    // Reset after 7 accepts of a 4x3 frame.
    cfg_width = 11'd4; cfg_height = 11'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; in_valid = 1'b1;
    n = 0; guard = 0;
    while (n < 7 && guard < 50) begin
      @(negedge clock);
      if (in_valid && in_ready) n++;
      @(posedge clock); #1;
      guard++;
    end
    chk("rst_accepts_before", n, 7);
    chk("rst_valid_before", {out_valid, busy}, 2'b11);
    reset = 1'b1;
    #1;
    chk("rst_outputs_async", {in_ready, win_shift, on_edge, out_valid, busy, done, cfg_err}, 7'b0);
    stray = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (done || out_valid || busy) stray = 1'b1;
    end
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (done || out_valid || busy || win_shift) stray = 1'b1;
    end
    chk("rst_no_done_or_valid", stray, 1'b0);
    @(posedge clock); #1;
    run_frame(11'd4, 11'd3, 1'b0, -1);
    chk("rst_clean_timeout", r_timeout, 1'b0);
    chk("rst_clean_valids", r_valids, 12);
    chk("rst_clean_edge_bits", r_ebits, 64'hF9F);

    // Start pulsed during RUN is ignored.
    run_frame(11'd4, 11'd3, 1'b0, 8);
    chk("runstart_timeout", r_timeout, 1'b0);
    chk("runstart_accepts", r_acc, 12);
    chk("runstart_valids", r_valids, 12);
    chk("runstart_edge_bits", r_ebits, 64'hF9F);
    chk("runstart_done_gap", r_done_gap, 1);

`ifdef SOBEL_SEQ_FRAME_COUNT_EN
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("fc_after_reset", frame_count, 16'd0);
    repeat (3) run_frame(11'd3, 11'd3, 1'b0, -1);
    @(negedge clock);
    chk("fc_three_frames", frame_count, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
